bldc_driver: RTL and testbench
==============================

// Module: bldc_driver
// PURPOSE
//  Sensored 3-phase BLDC drive core: six-step hall commutation with soft-start PWM and dead time,
//  a x4 quadrature encoder counter, and an encoder-vs-hall plausibility checker.
//  Sits between the SPI register file and the gate drivers, one instance per motor.
// PARAMETERS
//  PHASE_DRIVER_MAX_COUNTER  'h1FF  PWM counter top; period = value+1 clk cycles
//  MAX_DUTY_CYCLE            'h1FF  max duty; DUTY_W = ceil(log2(MAX_DUTY_CYCLE)) = 9
//  DUTY_CYCLE_STEP_RES       1      soft-start increment per PWM period
//  DEAD_TIME                 10     all-phases-off clk cycles on every commutation change
//  ENCODER_COUNT_WIDTH       15     signed encoder counter width
//  ENC_CHECK_HALL_EDGES      4      consecutive hall steps without encoder motion -> fault
// PORTS
//  clk              in   1        system clock
//  reset_n          in   1        async active-low reset
//  en               in   1        drive enable; low = all phases off, ramp and faults cleared
//  reset_enc_count  in   1        sync clear of enc_count
//  direction        in   1        1 = forward table, 0 = reverse
//  duty_cycle       in   DUTY_W   commanded magnitude, unsigned
//  hall             in   3        raw hall sensors {C,B,A}
//  enc              in   2        raw quadrature {B,A}
//  phaseH/phaseL    out  3        high/low-side gate enables, bit0=A, bit1=B, bit2=C
//  enc_count        out  ENCODER_COUNT_WIDTH  signed encoder position
//  connected        out  1        hall sensors present
//  hall_fault       out  1        illegal hall code/transition (sticky)
//  enc_fault        out  1        encoder stalled while halls move (sticky)
// BEHAVIOUR
//  - Reset: phaseH=phaseL=0, enc_count=0, faults=0, connected=0, ramp=0, PWM counter=0.
//  - hall and enc pass through 2-FF synchronizers; all logic uses synced values (2-cycle latency).
//  - connected = (synced hall != 3'b111); registered.
//  - hall_fault sets on synced hall==000, or when a change is not to an adjacent table entry;
//    stays set until en low.
//  - Forward table hall->(H,L): 101:(A,B) 100:(A,C) 110:(B,C) 010:(B,A) 011:(C,A) 001:(C,B);
//    direction=0 swaps H and L.
//  - PWM counter runs 0..PHASE_DRIVER_MAX_COUNTER, wraps. Active H bit = (cnt < ramp); active L bit
//    held on. H and L of the same phase are never both 1.
//  - Any change of commanded (H,L) pair: all outputs 0 for DEAD_TIME cycles, then the new pair.
//  - Soft-start: at each counter wrap, ramp += DUTY_CYCLE_STEP_RES, saturating at
//    min(duty_cycle, MAX_DUTY_CYCLE); a lower command loads immediately.
//  - Outputs forced 0 and ramp=0 while !en | !connected | hall_fault | enc_fault.
//  - Encoder: x4 decode; valid Gray step +-1, no change or double-bit change = no count.
//    Two's-complement wrap at the width limits. reset_enc_count wins over a simultaneous step.
//  - Checker (en high): counts hall steps since the last encoder change; encoder change clears it,
//    reaching ENC_CHECK_HALL_EDGES sets enc_fault. enc_fault is sticky until en low.
// CONFIGURATION
//  ENC_CHECK_EN defined: checker as above.
//  ENC_CHECK_EN undefined: checker not built, enc_fault tied 0.
// TESTING
//  - Reset, hall=111 -> connected=0, all phases 0; hall=101, en=1 -> connected=1 after 3 clk.
//  - hall=101, duty=200, en=1 -> ramp +1 per 512-clk period; phaseH[0] high 200/512 after 200 periods; phaseL[1]=1.
//  - Step hall 101->100 -> 10 clk all outputs 0, then phaseL[2]=1, phaseH[0] PWM.
//  - hall 101->010 jump, or hall=000 -> hall_fault=1, outputs 0; en low then high -> fault clears.
//  - 16 forward enc Gray steps -> enc_count=16; reverse 20 -> -4; reset_enc_count -> 0 next clk.
//  - ENC_CHECK_EN set: 4 hall steps with enc frozen -> enc_fault=1; not set -> stays 0.

Source files
------------

// File: rtl/bldc_driver.sv
// bldc_driver: six-step hall commutation with soft-start PWM and dead time, a x4 quadrature
// counter, and an encoder-vs-hall stall checker built only when ENC_CHECK_EN is defined.
module bldc_driver #(
    parameter int unsigned PHASE_DRIVER_MAX_COUNTER = 'h1FF,
    parameter int unsigned MAX_DUTY_CYCLE           = 'h1FF,
    parameter int unsigned DUTY_CYCLE_STEP_RES      = 1,
    parameter int unsigned DEAD_TIME                = 10,
    parameter int unsigned ENCODER_COUNT_WIDTH      = 15,
    parameter int unsigned ENC_CHECK_HALL_EDGES     = 4,
    localparam int unsigned DUTY_W = $clog2(MAX_DUTY_CYCLE)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           reset_enc_count,
    input  logic                           direction,
    input  logic [DUTY_W-1:0]              duty_cycle,
    input  logic [2:0]                     hall,
    input  logic [1:0]                     enc,
    output logic [2:0]                     phaseH,
    output logic [2:0]                     phaseL,
    output logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
    output logic                           connected,
    output logic                           hall_fault,
    output logic                           enc_fault
);
    localparam int unsigned CNT_W = $clog2(PHASE_DRIVER_MAX_COUNTER + 1);
    localparam int unsigned DT_W  = $clog2(DEAD_TIME + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PHASE_DRIVER_MAX_COUNTER);
    localparam logic [ENCODER_COUNT_WIDTH-1:0] ENC_ONE = ENCODER_COUNT_WIDTH'(1);

    typedef enum logic {ST_DRIVE, ST_DEAD} drive_state_e;

    logic [2:0]  hall_s1_q, hall_s2_q, hall_q;
    logic [1:0]  enc_s1_q, enc_s2_q, enc_q;
    logic        connected_q, hall_fault_q, hall_fault_d, enc_fault_w;
    logic [2:0]  pos_now, pos_prev, fwd_h, fwd_l, cmd_h, cmd_l;
    logic        hall_changed, hall_bad, gate, pair_change, pwm_on;
    drive_state_e state_q, state_d;
    logic [DT_W-1:0]   dead_q, dead_d;
    logic [2:0]        pair_h_q, pair_h_d, pair_l_q, pair_l_d;
    logic [2:0]        phase_h_q, phase_h_d, phase_l_q, phase_l_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DUTY_W-1:0] ramp_q, ramp_d, limit;
    logic [DUTY_W:0]   ramp_inc;
    logic [ENCODER_COUNT_WIDTH-1:0] enc_count_q, enc_count_d;

    // Position of a hall code in the forward commutation sequence; 7 = not a table entry.
    function automatic logic [2:0] hall_pos(input logic [2:0] h);
        case (h)
            3'b101:  hall_pos = 3'd0;
            3'b100:  hall_pos = 3'd1;
            3'b110:  hall_pos = 3'd2;
            3'b010:  hall_pos = 3'd3;
            3'b011:  hall_pos = 3'd4;
            3'b001:  hall_pos = 3'd5;
            default: hall_pos = 3'd7;
        endcase
    endfunction

    always_comb begin
        pos_now      = hall_pos(hall_s2_q);
        pos_prev     = hall_pos(hall_q);
        hall_changed = (hall_s2_q != hall_q);
        hall_bad     = (hall_s2_q == 3'b000);
        if (hall_changed && pos_now != 3'd7 && pos_prev != 3'd7) begin
            if (!(pos_now == pos_prev + 3'd1 || pos_prev == pos_now + 3'd1 ||
                  (pos_now == 3'd0 && pos_prev == 3'd5) || (pos_now == 3'd5 && pos_prev == 3'd0)))
                hall_bad = 1'b1;
        end
        case (pos_now)
            3'd0:    {fwd_h, fwd_l} = {3'b001, 3'b010};
            3'd1:    {fwd_h, fwd_l} = {3'b001, 3'b100};
            3'd2:    {fwd_h, fwd_l} = {3'b010, 3'b100};
            3'd3:    {fwd_h, fwd_l} = {3'b010, 3'b001};
            3'd4:    {fwd_h, fwd_l} = {3'b100, 3'b001};
            3'd5:    {fwd_h, fwd_l} = {3'b100, 3'b010};
            default: {fwd_h, fwd_l} = '0;
        endcase
        cmd_h = direction ? fwd_h : fwd_l;
        cmd_l = direction ? fwd_l : fwd_h;
        hall_fault_d = en ? (hall_fault_q | hall_bad) : 1'b0;
    end

    assign gate = en && connected_q && !hall_fault_q && !enc_fault_w;

    // The cycle the pair changes is itself blanked, so DEAD_TIME-1 more cycles complete the gap.
    always_comb begin
        state_d     = state_q;
        dead_d      = dead_q;
        pair_h_d    = pair_h_q;
        pair_l_d    = pair_l_q;
        pair_change = (cmd_h != pair_h_q) || (cmd_l != pair_l_q);
        if (pair_change) begin
            pair_h_d = cmd_h;
            pair_l_d = cmd_l;
            dead_d   = DT_W'(DEAD_TIME - 1);
            state_d  = (DEAD_TIME > 1) ? ST_DEAD : ST_DRIVE;
        end else if (state_q == ST_DEAD) begin
            dead_d = dead_q - DT_W'(1);
            if (dead_q <= DT_W'(1)) state_d = ST_DRIVE;
        end
        pwm_on    = (32'(cnt_q) < 32'(ramp_q));
        phase_h_d = '0;
        phase_l_d = '0;
        if (gate && !pair_change && state_q == ST_DRIVE) begin
            phase_h_d = pair_h_q & {3{pwm_on}};
            phase_l_d = pair_l_q;
        end
    end

    always_comb begin
        limit    = (32'(duty_cycle) > MAX_DUTY_CYCLE) ? DUTY_W'(MAX_DUTY_CYCLE) : duty_cycle;
        ramp_inc = {1'b0, ramp_q} + (DUTY_W + 1)'(DUTY_CYCLE_STEP_RES);
        ramp_d   = ramp_q;
        if (!gate)
            ramp_d = '0;
        else if (ramp_q > limit)
            ramp_d = limit;
        else if (cnt_q == CNT_TOP)
            ramp_d = (ramp_inc >= {1'b0, limit}) ? limit : ramp_inc[DUTY_W-1:0];
    end

    always_comb begin
        enc_count_d = enc_count_q;
        case ({enc_q, enc_s2_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: enc_count_d = enc_count_q + ENC_ONE;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: enc_count_d = enc_count_q - ENC_ONE;
            default: ;
        endcase
        if (reset_enc_count) enc_count_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hall_s1_q    <= 3'b111;
            hall_s2_q    <= 3'b111;
            hall_q       <= 3'b111;
            enc_s1_q     <= '0;
            enc_s2_q     <= '0;
            enc_q        <= '0;
            connected_q  <= 1'b0;
            hall_fault_q <= 1'b0;
            state_q      <= ST_DRIVE;
            dead_q       <= '0;
            pair_h_q     <= '0;
            pair_l_q     <= '0;
            phase_h_q    <= '0;
            phase_l_q    <= '0;
            cnt_q        <= '0;
            ramp_q       <= '0;
            enc_count_q  <= '0;
        end else begin
            hall_s1_q    <= hall;
            hall_s2_q    <= hall_s1_q;
            hall_q       <= hall_s2_q;
            enc_s1_q     <= enc;
            enc_s2_q     <= enc_s1_q;
            enc_q        <= enc_s2_q;
            connected_q  <= (hall_s2_q != 3'b111);
            hall_fault_q <= hall_fault_d;
            state_q      <= state_d;
            dead_q       <= dead_d;
            pair_h_q     <= pair_h_d;
            pair_l_q     <= pair_l_d;
            phase_h_q    <= phase_h_d;
            phase_l_q    <= phase_l_d;
            cnt_q        <= (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
            ramp_q       <= ramp_d;
            enc_count_q  <= enc_count_d;
        end
    end

`ifdef ENC_CHECK_EN
    localparam int unsigned EW = $clog2(ENC_CHECK_HALL_EDGES + 1);
    logic [EW-1:0] edges_q, edges_d;
    logic          enc_fault_q, enc_fault_d;

    always_comb begin
        edges_d     = edges_q;
        enc_fault_d = enc_fault_q;
        if (!en) begin
            edges_d     = '0;
            enc_fault_d = 1'b0;
        end else if (enc_q != enc_s2_q) begin
            edges_d = '0;
        end else if (hall_changed && 32'(edges_q) < ENC_CHECK_HALL_EDGES) begin
            edges_d = edges_q + EW'(1);
            if (32'(edges_q) + 1 >= ENC_CHECK_HALL_EDGES) enc_fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edges_q     <= '0;
            enc_fault_q <= 1'b0;
        end else begin
            edges_q     <= edges_d;
            enc_fault_q <= enc_fault_d;
        end
    end

    assign enc_fault_w = enc_fault_q;
`else
    assign enc_fault_w = 1'b0;
`endif

    assign phaseH     = phase_h_q;
    assign phaseL     = phase_l_q;
    assign enc_count  = enc_count_q;
    assign connected  = connected_q;
    assign hall_fault = hall_fault_q;
    assign enc_fault  = enc_fault_w;
endmodule

// File: tb/tb_bldc_driver.sv
// Bench for bldc_driver: PWM pulse widths and encoder count changes are scoreboarded against a
// behavioural model; commutation, dead time, faults and connection are checked inline.
module tb_bldc_driver;
    localparam int unsigned STEP   = 7;
    localparam int unsigned EW     = 6;
    localparam int unsigned DT     = 10;
    localparam int unsigned PERIOD = 512;
`ifdef ENC_CHECK_EN
    localparam int ENC_CHK = 1;
`else
    localparam int ENC_CHK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, en, reset_enc_count, direction;
    logic [8:0]    duty_cycle;
    logic [2:0]    hall;
    logic [1:0]    enc;
    logic [2:0]    phaseH, phaseL;
    logic [EW-1:0] enc_count;
    logic          connected, hall_fault, enc_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bldc_driver #(.DUTY_CYCLE_STEP_RES(STEP), .ENCODER_COUNT_WIDTH(EW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .reset_enc_count(reset_enc_count),
        .direction(direction), .duty_cycle(duty_cycle), .hall(hall), .enc(enc),
        .phaseH(phaseH), .phaseL(phaseL), .enc_count(enc_count), .connected(connected),
        .hall_fault(hall_fault), .enc_fault(enc_fault));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboards: expected phase-A high-pulse widths and expected successive enc_count values.
    int pulse_q[$];
    int encx_q[$];
    bit sb_on    = 1'b0;
    int pulses   = 0;
    int plen     = 0;
    int enc_last = 0;
    int overlap  = 0;
    int cur_enc;

    always @(negedge clk) begin
        if (reset_n) begin
            if ((phaseH & phaseL) != 3'b000) overlap++;
            if (phaseH[0]) plen++;
            else if (plen != 0) begin
                pulses++;
                if (sb_on) begin
                    if (pulse_q.size() == 0) check("pulse_unexpected", plen, 0);
                    else check("pulse_width", plen, pulse_q.pop_front());
                end
                plen = 0;
            end
            cur_enc = int'($signed(enc_count));
            if (cur_enc != enc_last) begin
                if (encx_q.size() == 0) check("enc_unexpected", cur_enc, enc_last);
                else check("enc_count_step", cur_enc, encx_q.pop_front());
                enc_last = cur_enc;
            end
        end
    end

    // Encoder model: quadrature phase index and signed position.
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int enc_ph  = 0;
    int enc_pos = 0;

    function automatic int wrapc(input int v);
        int m = 1 << EW;
        int h = 1 << (EW - 1);
        return (((v + h) % m) + m) % m - h;
    endfunction

    task automatic model_set(input int v);
        int w = wrapc(v);
        if (w != enc_pos) encx_q.push_back(w);
        enc_pos = w;
    endtask

    // kind: 0 hold, 1 forward step, 2 reverse step, 3 double-bit jump
    task automatic enc_move(input int kind);
        int np;
        case (kind)
            1:       np = (enc_ph + 1) % 4;
            2:       np = (enc_ph + 3) % 4;
            3:       np = (enc_ph + 2) % 4;
            default: np = enc_ph;
        endcase
        if (kind == 1) model_set(enc_pos + 1);
        else if (kind == 2) model_set(enc_pos - 1);
        enc_ph = np;
        enc    = gray[np];
        repeat (4) @(negedge clk);
    endtask

    // Commutation table {H mask, L mask}; bit0=A, bit1=B, bit2=C.
    function automatic logic [5:0] hall_pair(input logic [2:0] h, input bit dir);
        logic [2:0] hm, lm;
        case (h)
            3'b101:  begin hm = 3'b001; lm = 3'b010; end
            3'b100:  begin hm = 3'b001; lm = 3'b100; end
            3'b110:  begin hm = 3'b010; lm = 3'b100; end
            3'b010:  begin hm = 3'b010; lm = 3'b001; end
            3'b011:  begin hm = 3'b100; lm = 3'b001; end
            3'b001:  begin hm = 3'b100; lm = 3'b010; end
            default: begin hm = 3'b000; lm = 3'b000; end
        endcase
        return dir ? {hm, lm} : {lm, hm};
    endfunction

    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    task automatic wait_pulses(input int n, input string name);
        int target = pulses + n;
        int cyc    = 0;
        while (pulses < target && cyc < (n + 2) * PERIOD) begin
            @(negedge clk);
            cyc++;
        end
        check(name, int'(pulses >= target), 1);
    endtask

    task automatic commutate(input logic [2:0] nh, input bit nd, input string name);
        logic [5:0] p;
        logic [2:0] hor;
        int zeros = 0, cyc = 0, hleak = 0;
        enc_move(1);
        p         = hall_pair(nh, nd);
        hall      = nh;
        direction = nd;
        while (phaseL != 3'b000 && cyc < 20) begin @(negedge clk); cyc++; end
        while (phaseL == 3'b000 && cyc < 60) begin
            if (phaseH != 3'b000) hleak++;
            zeros++;
            @(negedge clk);
            cyc++;
        end
        check({name, " dead_len"}, zeros, DT);
        check({name, " dead_h"}, hleak, 0);
        check({name, " low_side"}, phaseL, p[2:0]);
        hor = '0;
        repeat (PERIOD + 8) begin @(negedge clk); hor |= phaseH; end
        check({name, " high_side"}, hor, p[5:3]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hidx;
        logic [5:0] p;
        reset_n = 1'b0; en = 1'b0; reset_enc_count = 1'b0; direction = 1'b1;
        duty_cycle = 9'd200; hall = 3'b111; enc = 2'b00;
        repeat (3) @(negedge clk);
        check("rst phaseH", phaseH, 0);
        check("rst phaseL", phaseL, 0);
        check("rst enc_count", enc_count, 0);
        check("rst connected", connected, 0);
        check("rst hall_fault", hall_fault, 0);
        check("rst enc_fault", enc_fault, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("hall111 connected", connected, 0);
        check("hall111 phases", phaseH | phaseL, 0);

        // Soft start: widths grow by STEP per period, saturating at the command.
        for (int k = 1; k <= 31; k++) pulse_q.push_back((k * STEP > 200) ? 200 : k * STEP);
        sb_on = 1'b1;
        hall = 3'b101; en = 1'b1;
        repeat (2) @(negedge clk);
        check("connected before 3clk", connected, 0);
        @(negedge clk);
        check("connected at 3clk", connected, 1);
        wait_pulses(31, "ramp pulses timeout");
        check("ramp low side B", phaseL, 3'b010);
        duty_cycle = 9'd50;
        pulse_q.push_back(50);
        wait_pulses(1, "lower duty timeout");
        duty_cycle = 9'd64;
        pulse_q.push_back(57);
        pulse_q.push_back(64);
        wait_pulses(2, "raise duty timeout");
        check("pulse queue drained", pulse_q.size(), 0);
        sb_on = 1'b0;

        // Commutation around the table, then with direction reversed.
        hidx = 0;
        for (int i = 1; i <= 6; i++) begin
            hidx = (hidx + 1) % 6;
            commutate(seq[hidx], 1'b1, $sformatf("fwd%0d", i));
        end
        commutate(seq[hidx], 1'b0, "dirflip");
        for (int i = 1; i <= 2; i++) begin
            hidx = (hidx + 1) % 6;
            commutate(seq[hidx], 1'b0, $sformatf("rev%0d", i));
        end
        direction = 1'b1;
        repeat (20) @(negedge clk);

        // Hall faults: non-adjacent jump and all-zero code.
        enc_move(1);
        hidx = (hidx + 3) % 6;
        hall = seq[hidx];
        repeat (5) @(negedge clk);
        check("jump hall_fault", hall_fault, 1);
        check("jump phases off", phaseH | phaseL, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("jump fault cleared", hall_fault, 0);
        en = 1'b1;
        repeat (30) @(negedge clk);
        p = hall_pair(seq[hidx], 1'b1);
        check("jump fault stays clear", hall_fault, 0);
        check("recover low side", phaseL, p[2:0]);
        hall = 3'b000;
        repeat (5) @(negedge clk);
        check("zero hall_fault", hall_fault, 1);
        check("zero phases off", phaseH | phaseL, 0);
        en = 1'b0;
        hall = seq[hidx];
        repeat (5) @(negedge clk);
        check("zero fault cleared", hall_fault, 0);
        en = 1'b1;
        repeat (30) @(negedge clk);
        check("zero fault stays clear", hall_fault, 0);
        hall = 3'b111;
        repeat (5) @(negedge clk);
        check("unplugged connected", connected, 0);
        check("unplugged phases off", phaseH | phaseL, 0);
        check("unplugged no fault", hall_fault, 0);
        hall = seq[hidx];
        repeat (5) @(negedge clk);

        // Encoder stall checker: four hall steps with the encoder frozen.
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (30) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            hidx = (hidx + 1) % 6;
            hall = seq[hidx];
            repeat (25) @(negedge clk);
        end
        check("stall 3 steps", enc_fault, 0);
        hidx = (hidx + 1) % 6;
        hall = seq[hidx];
        repeat (25) @(negedge clk);
        p = hall_pair(seq[hidx], 1'b1);
        check("stall 4 steps", enc_fault, ENC_CHK);
        check("stall low side", phaseL, (ENC_CHK != 0) ? 0 : int'(p[2:0]));
        check("stall hall_fault", hall_fault, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("stall cleared", enc_fault, 0);

        // Encoder counter.
        reset_enc_count = 1'b1;
        model_set(0);
        @(negedge clk);
        check("enc clear next clk", enc_count, 0);
        reset_enc_count = 1'b0;
        repeat (16) enc_move(1);
        check("enc fwd16", int'($signed(enc_count)), 16);
        repeat (20) enc_move(2);
        check("enc rev20", int'($signed(enc_count)), -4);
        reset_enc_count = 1'b1;
        model_set(0);
        @(negedge clk);
        check("enc clear from -4", enc_count, 0);
        reset_enc_count = 1'b0;
        enc_ph = (enc_ph + 1) % 4;
        enc = gray[enc_ph];
        repeat (2) @(negedge clk);
        reset_enc_count = 1'b1;
        @(negedge clk);
        reset_enc_count = 1'b0;
        repeat (4) @(negedge clk);
        check("clear beats step", enc_count, 0);
        repeat (40) enc_move(1);
        check("enc wrap", int'($signed(enc_count)), wrapc(40));
        repeat (150) enc_move(int'($urandom_range(0, 3)));
        check("enc random final", int'($signed(enc_count)), enc_pos);
        check("enc queue drained", encx_q.size(), 0);
        check("H/L overlap cycles", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
